// File: rtl/aes_block_assembler_if.sv
// Byte-in / block-out stream bundle between the UART receiver, the
// assembler and the AES core.
interface aes_block_assembler_if #(
   parameter int NBYTES = 16
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   out_data;

   // master: the environment (receiver + core side)
   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data
   );

   // slave: the assembler itself
   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/aes_block_assembler.sv
// Packs NBYTES received bytes into one AES block. The shift buffer keeps
// filling while the holding register waits for the core. Sticky flags
// record dropped blocks (overflow) and partial blocks discarded by the
// inter-byte idle timer (timeout_err).
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | holding register free, out_valid = 0
// FULL  | holding register has a complete block, out_valid = 1
module aes_block_assembler #(
   parameter int NBYTES      = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      rstn,
   aes_block_assembler_if.slave      bus,
   output logic [$clog2(NBYTES):0]   byte_cnt,
   output logic                      overflow,
   output logic                      timeout_err,
   input  logic                      clr_err
);
   localparam int W  = 8 * NBYTES;
   localparam int CW = $clog2(NBYTES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC - 1);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t          state_q, state_d;
   // Only NBYTES-1 bytes need storing: the last byte of a block goes
   // straight from in_data into the holding register.
   logic [W-9:0]    sbuf_q, sbuf_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            overflow_q, overflow_d;
   logic            timeout_err_q, timeout_err_d;

   logic            handshake;
   logic            complete;
   logic [W-1:0]    block;
   logic            ovf_set;
   logic            to_set;

   assign handshake = (state_q == FULL) && bus.out_ready;
   assign complete  = bus.in_valid && (byte_cnt_q == LAST_CNT);
   assign block     = {sbuf_q, bus.in_data};

   // Next-state: shift buffer, byte counter, idle timer, holding FSM, flags
   always_comb begin
      state_d       = state_q;
      sbuf_d        = sbuf_q;
      out_data_d    = out_data_q;
      byte_cnt_d    = byte_cnt_q;
      timer_d       = timer_q;
      ovf_set       = 1'b0;
      to_set        = 1'b0;

      if (bus.in_valid) begin
         sbuf_d  = block[W-9:0];
         timer_d = '0;
         if (complete) byte_cnt_d = '0;
         else          byte_cnt_d = byte_cnt_q + 1'b1;
      end else if (byte_cnt_q == '0) begin
         timer_d = '0;
      end else if (timer_q == TMAX) begin
         // Stalled partial block: drop it; stale sbuf bytes are shifted
         // out by the next NBYTES-1 bytes before they can be presented.
         byte_cnt_d = '0;
         timer_d    = '0;
         to_set     = 1'b1;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      case (state_q)
         EMPTY: begin
            if (complete) begin
               out_data_d = block;
               state_d    = FULL;
            end
         end
         FULL: begin
            if (complete) begin
               // A handshake in the same cycle frees the slot for the new block.
               if (handshake) out_data_d = block;
               else           ovf_set    = 1'b1;
            end else if (handshake) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase

      overflow_d    = ovf_set | (overflow_q    & ~clr_err);
      timeout_err_d = to_set  | (timeout_err_q & ~clr_err);
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= EMPTY;
         sbuf_q        <= '0;
         out_data_q    <= '0;
         byte_cnt_q    <= '0;
         timer_q       <= '0;
         overflow_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sbuf_q        <= sbuf_d;
         out_data_q    <= out_data_d;
         byte_cnt_q    <= byte_cnt_d;
         timer_q       <= timer_d;
         overflow_q    <= overflow_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = out_data_q;
   assign byte_cnt      = byte_cnt_q;
   assign overflow      = overflow_q;
   assign timeout_err   = timeout_err_q;
endmodule
